// File: rtl/id_pkg.sv
// Shared decode constants for the ID stage: opcodes, ALUOp encodings and
// the control-word layout carried through ID/EX.
package id_pkg;

  localparam int unsigned CTRL_W = 9;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_FUNCT = 3'b010,
    ALU_AND   = 3'b011,
    ALU_OR    = 3'b100
  } aluop_e;

  localparam int unsigned CB_MEMTOREG = 0;
  localparam int unsigned CB_REGWRITE = 1;
  localparam int unsigned CB_MEMWRITE = 2;
  localparam int unsigned CB_MEMREAD  = 3;
  localparam int unsigned CB_ALUSRC   = 4;
  localparam int unsigned CB_ALUOP_LO = 5;
  localparam int unsigned CB_REGDST   = 8;

  // Field order matches the CB_* bit positions (MSB first).
  typedef struct packed {
    logic   reg_dst;
    aluop_e alu_op;
    logic   alu_src;
    logic   mem_read;
    logic   mem_write;
    logic   reg_write;
    logic   mem_to_reg;
  } ctrl_t;

  function automatic logic op_known(input logic [5:0] op);
    logic k;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI: k = 1'b1;
      default:                                                  k = 1'b0;
    endcase
    return k;
  endfunction

  function automatic ctrl_t decode_ctrl(input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin
        c.reg_dst   = 1'b1;
        c.alu_op    = ALU_FUNCT;
        c.reg_write = 1'b1;
      end
      OP_LW: begin
        c.alu_op     = ALU_ADD;
        c.alu_src    = 1'b1;
        c.mem_read   = 1'b1;
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        c.alu_op    = ALU_ADD;
        c.alu_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      OP_BEQ: begin
        c.alu_op = ALU_SUB;
      end
      OP_ADDI: begin
        c.alu_op    = ALU_ADD;
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
      end
      OP_ANDI: begin
        c.alu_op    = ALU_AND;
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
      end
      OP_ORI: begin
        c.alu_op    = ALU_OR;
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_stage_p_regfile.sv
// Register file for the ID stage: two combinational read ports, one write
// port, r0 hard-wired to zero, optional same-cycle write-back forwarding.
module regfile_p #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned BYPASS = 1,
  parameter int unsigned AW     = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   ra1_i,
  input  logic [AW-1:0]   ra2_i,
  output logic [XLEN-1:0] rd1_o,
  output logic [XLEN-1:0] rd2_o,
  input  logic            we_i,
  input  logic [AW-1:0]   wa_i,
  input  logic [XLEN-1:0] wd_i
);

  logic [XLEN-1:0] mem_q [NREGS];
  logic            wr_en;

  assign wr_en = we_i && (wa_i != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  // wr_en already excludes r0, so forwarding can never make r0 nonzero.
  always_comb begin
    rd1_o = (ra1_i == '0) ? '0 : mem_q[ra1_i];
    rd2_o = (ra2_i == '0) ? '0 : mem_q[ra2_i];
    if (BYPASS != 0 && wr_en && (wa_i == ra1_i)) rd1_o = wd_i;
    if (BYPASS != 0 && wr_en && (wa_i == ra2_i)) rd2_o = wd_i;
  end

endmodule

// File: rtl/id_stage_p.sv
// Instruction-decode stage: decode, register read, immediate extension,
// load-use hazard detection and the registered ID/EX pipeline register.
module id_stage_p
  import id_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned BYPASS = 1,
  parameter int unsigned AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  input  logic [31:0]       if_instr,
  input  logic              wb_we,
  input  logic [AW-1:0]     wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  input  logic              ex_hold,
  output logic              stall_out,
  output logic              ex_valid,
  output logic [31:0]       ex_instr,
  output logic [XLEN-1:0]   ex_a,
  output logic [XLEN-1:0]   ex_b,
  output logic [XLEN-1:0]   ex_imm_s,
  output logic [XLEN-1:0]   ex_imm_z,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_illegal
);

  logic [5:0]      opcode;
  logic [4:0]      rs, rt, rd;
  logic [15:0]     imm;
  logic [XLEN-1:0] rs_val, rt_val;
  logic [XLEN-1:0] imm_s, imm_z;
  ctrl_t           dec_ctrl;
  logic            dec_ill;
  logic [4:0]      ld_rt;
  logic            haz;
  logic            bubble;

  logic            ex_valid_q;
  logic [31:0]     ex_instr_q;
  logic [XLEN-1:0] ex_a_q, ex_b_q, ex_imm_s_q, ex_imm_z_q;
  ctrl_t           ex_ctrl_q;
  logic            ex_illegal_q;

  assign opcode = if_instr[31:26];
  assign rs     = if_instr[25:21];
  assign rt     = if_instr[20:16];
  assign rd     = if_instr[15:11];
  assign imm    = if_instr[15:0];

  regfile_p #(
    .XLEN   (XLEN),
    .NREGS  (NREGS),
    .BYPASS (BYPASS)
  ) u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1_i (rs[AW-1:0]),
    .ra2_i (rt[AW-1:0]),
    .rd1_o (rs_val),
    .rd2_o (rt_val),
    .we_i  (wb_we),
    .wa_i  (wb_rd),
    .wd_i  (wb_data)
  );

  // Shift form avoids a reversed slice when AW is already 5.
  function automatic logic field_oob(input logic [4:0] f);
    return (f >> AW) != 5'd0;
  endfunction

  assign imm_s = {{(XLEN-16){imm[15]}}, imm};
  assign imm_z = {{(XLEN-16){1'b0}}, imm};

  always_comb begin
    dec_ctrl = decode_ctrl(opcode);
    dec_ill  = !op_known(opcode) || field_oob(rs) || field_oob(rt) ||
               ((opcode == OP_RTYPE) && field_oob(rd));
    if (dec_ill || !if_valid) dec_ctrl = '0;
    if (!if_valid)            dec_ill  = 1'b0;
  end

  assign ld_rt = ex_instr_q[20:16];
  assign haz   = if_valid && ex_valid_q && ex_ctrl_q.mem_read &&
                 (ld_rt != 5'd0) && ((ld_rt == rs) || (ld_rt == rt));

  assign stall_out = !flush && (ex_hold || haz);
  assign bubble    = flush || (!ex_hold && haz);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q   <= 1'b0;
      ex_instr_q   <= '0;
      ex_a_q       <= '0;
      ex_b_q       <= '0;
      ex_imm_s_q   <= '0;
      ex_imm_z_q   <= '0;
      ex_ctrl_q    <= '0;
      ex_illegal_q <= 1'b0;
    end else if (bubble) begin
      ex_valid_q   <= 1'b0;
      ex_instr_q   <= '0;
      ex_a_q       <= '0;
      ex_b_q       <= '0;
      ex_imm_s_q   <= '0;
      ex_imm_z_q   <= '0;
      ex_ctrl_q    <= '0;
      ex_illegal_q <= 1'b0;
    end else if (!ex_hold) begin
      ex_valid_q   <= if_valid;
      ex_instr_q   <= if_instr;
      ex_a_q       <= rs_val;
      ex_b_q       <= rt_val;
      ex_imm_s_q   <= imm_s;
      ex_imm_z_q   <= imm_z;
      ex_ctrl_q    <= dec_ctrl;
      ex_illegal_q <= dec_ill;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_instr   = ex_instr_q;
  assign ex_a       = ex_a_q;
  assign ex_b       = ex_b_q;
  assign ex_imm_s   = ex_imm_s_q;
  assign ex_imm_z   = ex_imm_z_q;
  assign ex_ctrl    = ex_ctrl_q;
  assign ex_illegal = ex_illegal_q;

endmodule

// File: tb/tb_id_stage_p.sv
// Bench for id_stage_p: four parameter variants driven by shared stimulus and
// checked against a behavioural model of the decode stage.
module tb_id_stage_p;

  localparam int NI = 4;
  localparam int unsigned XL [NI] = '{32, 32, 64, 32};
  localparam int unsigned NR [NI] = '{32, 32, 32, 16};
  localparam int unsigned BP [NI] = '{1, 0, 1, 1};

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, if_valid, wb_we, flush, ex_hold;
  logic [31:0] if_instr;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;

  logic        stall [NI];
  logic        vld   [NI];
  logic [31:0] ins   [NI];
  logic [8:0]  ctl   [NI];
  logic        ill   [NI];
  logic [31:0] a32 [3], b32 [3], s32 [3], z32 [3];
  logic [63:0] a64, b64, s64, z64;

  int checks = 0;
  int errors = 0;

  id_stage_p #(.XLEN(32), .NREGS(32), .BYPASS(1)) u_d0 (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data[31:0]), .flush(flush),
    .ex_hold(ex_hold), .stall_out(stall[0]), .ex_valid(vld[0]), .ex_instr(ins[0]),
    .ex_a(a32[0]), .ex_b(b32[0]), .ex_imm_s(s32[0]), .ex_imm_z(z32[0]),
    .ex_ctrl(ctl[0]), .ex_illegal(ill[0]));

  id_stage_p #(.XLEN(32), .NREGS(32), .BYPASS(0)) u_d1 (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data[31:0]), .flush(flush),
    .ex_hold(ex_hold), .stall_out(stall[1]), .ex_valid(vld[1]), .ex_instr(ins[1]),
    .ex_a(a32[1]), .ex_b(b32[1]), .ex_imm_s(s32[1]), .ex_imm_z(z32[1]),
    .ex_ctrl(ctl[1]), .ex_illegal(ill[1]));

  id_stage_p #(.XLEN(64), .NREGS(32), .BYPASS(1)) u_d2 (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .ex_hold(ex_hold), .stall_out(stall[2]), .ex_valid(vld[2]), .ex_instr(ins[2]),
    .ex_a(a64), .ex_b(b64), .ex_imm_s(s64), .ex_imm_z(z64),
    .ex_ctrl(ctl[2]), .ex_illegal(ill[2]));

  id_stage_p #(.XLEN(32), .NREGS(16), .BYPASS(1)) u_d3 (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr),
    .wb_we(wb_we), .wb_rd(wb_rd[3:0]), .wb_data(wb_data[31:0]), .flush(flush),
    .ex_hold(ex_hold), .stall_out(stall[3]), .ex_valid(vld[3]), .ex_instr(ins[3]),
    .ex_a(a32[2]), .ex_b(b32[2]), .ex_imm_s(s32[2]), .ex_imm_z(z32[2]),
    .ex_ctrl(ctl[3]), .ex_illegal(ill[3]));

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] s;
    logic [63:0] z;
    logic [8:0]  ctrl;
    logic        ill;
  } ex_t;

  logic [63:0] rf   [NI][32];
  ex_t         m_ex [NI];

  // ---------------- reference model ----------------
  function automatic logic [63:0] mask(input int k);
    return (XL[k] == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] m_read(input int k, input logic [4:0] f);
    int unsigned i = 32'(f) % NR[k];
    int unsigned w = 32'(wb_rd) % NR[k];
    if (i == 0) return 64'd0;
    if (BP[k] != 0 && wb_we && w != 0 && w == i) return wb_data & mask(k);
    return rf[k][i];
  endfunction

  // {known, RegDst, ALUOp[2:0], ALUSrc, MemRead, MemWrite, RegWrite, MemtoReg}
  function automatic logic [9:0] m_ctrl(input logic [5:0] op);
    case (op)
      6'h00:   return 10'b1_1_010_0_0_0_1_0;
      6'h23:   return 10'b1_0_000_1_1_0_1_1;
      6'h2b:   return 10'b1_0_000_1_0_1_0_0;
      6'h04:   return 10'b1_0_001_0_0_0_0_0;
      6'h08:   return 10'b1_0_000_1_0_0_1_0;
      6'h0c:   return 10'b1_0_011_1_0_0_1_0;
      6'h0d:   return 10'b1_0_100_1_0_0_1_0;
      default: return 10'b0;
    endcase
  endfunction

  function automatic logic m_haz(input int k);
    logic [4:0] ld = m_ex[k].instr[20:16];
    return if_valid && m_ex[k].valid && m_ex[k].ctrl[3] && ld != 5'd0 &&
           (ld == if_instr[25:21] || ld == if_instr[20:16]);
  endfunction

  function automatic logic m_stall(input int k);
    return !flush && (ex_hold || m_haz(k));
  endfunction

  function automatic ex_t m_next(input int k);
    ex_t         d;
    logic [9:0]  kc;
    logic [15:0] imm = if_instr[15:0];
    if (flush) return '0;
    if (ex_hold) return m_ex[k];
    if (m_haz(k)) return '0;
    kc      = m_ctrl(if_instr[31:26]);
    d.valid = if_valid;
    d.instr = if_instr;
    d.a     = m_read(k, if_instr[25:21]);
    d.b     = m_read(k, if_instr[20:16]);
    d.s     = {{48{imm[15]}}, imm} & mask(k);
    d.z     = {48'd0, imm};
    d.ill   = !kc[9] || 32'(if_instr[25:21]) >= NR[k] || 32'(if_instr[20:16]) >= NR[k] ||
              (if_instr[31:26] == 6'd0 && 32'(if_instr[15:11]) >= NR[k]);
    d.ctrl  = d.ill ? 9'd0 : kc[8:0];
    if (!if_valid) begin
      d.ctrl = 9'd0;
      d.ill  = 1'b0;
    end
    return d;
  endfunction

  function automatic void m_reset();
    for (int k = 0; k < NI; k++) begin
      m_ex[k] = '0;
      for (int i = 0; i < 32; i++) rf[k][i] = 64'd0;
    end
  endfunction

  function automatic ex_t obs(input int k);
    ex_t o;
    o.valid = vld[k];
    o.instr = ins[k];
    o.ctrl  = ctl[k];
    o.ill   = ill[k];
    if (k == 2) begin
      o.a = a64; o.b = b64; o.s = s64; o.z = z64;
    end else begin
      int j = (k == 3) ? 2 : k;
      o.a = {32'd0, a32[j]}; o.b = {32'd0, b32[j]};
      o.s = {32'd0, s32[j]}; o.z = {32'd0, z32[j]};
    end
    return o;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic v, input logic [31:0] instr, input logic we,
                       input logic [4:0] rd, input logic [63:0] d,
                       input logic fl, input logic hd);
    if_valid = v; if_instr = instr; wb_we = we; wb_rd = rd; wb_data = d;
    flush = fl; ex_hold = hd;
    #1;
  endtask

  task automatic tick();
    ex_t nx [NI];
    for (int k = 0; k < NI; k++) nx[k] = m_next(k);
    for (int k = 0; k < NI; k++) begin
      int unsigned w = 32'(wb_rd) % NR[k];
      if (wb_we && w != 0) rf[k][w] = wb_data & mask(k);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) m_ex[k] = nx[k];
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    return {6'd0, s, t, d, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s,
                                        input logic [4:0] t, input logic [15:0] im);
    return {op, s, t, im};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0);
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (obs(k) !== ex_t'(0) || stall[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset inst%0d got %h stall %b, expected all zero", k, obs(k), stall[k]);
      end
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_bypass();
    drive(1'b0, 32'd0, 1'b1, 5'd3, 64'h1111_1111, 1'b0, 1'b0);
    tick();
    drive(1'b1, rtype(5'd3, 5'd0, 5'd4), 1'b1, 5'd3, 64'hDEAD_BEEF, 1'b0, 1'b0);
    tick();
    checks++;
    if (a32[0] !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL bypass_on ex_a got %h expected deadbeef", a32[0]);
    end
    checks++;
    if (a32[1] !== 32'h1111_1111) begin
      errors++; $display("FAIL bypass_off ex_a got %h expected 11111111", a32[1]);
    end
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (obs(k) !== m_ex[k]) begin
        errors++; $display("FAIL bypass_model inst%0d got %h expected %h", k, obs(k), m_ex[k]);
      end
    end
  endtask

  task automatic test_load_use();
    drive(1'b1, itype(6'h23, 5'd1, 5'd2, 16'd0), 1'b0, 5'd0, 64'd0, 1'b0, 1'b0);
    tick();
    drive(1'b1, rtype(5'd2, 5'd2, 5'd3), 1'b0, 5'd0, 64'd0, 1'b0, 1'b0);
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (stall[k] !== 1'b1) begin
        errors++; $display("FAIL loaduse_stall inst%0d got %b expected 1", k, stall[k]);
      end
    end
    tick();
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (vld[k] !== 1'b0 || obs(k) !== m_ex[k]) begin
        errors++; $display("FAIL loaduse_bubble inst%0d got %h expected %h", k, obs(k), m_ex[k]);
      end
    end
    drive(1'b1, rtype(5'd2, 5'd2, 5'd3), 1'b0, 5'd0, 64'd0, 1'b0, 1'b0);
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (stall[k] !== 1'b0) begin
        errors++; $display("FAIL loaduse_release inst%0d got %b expected 0", k, stall[k]);
      end
    end
    tick();
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (vld[k] !== 1'b1 || ctl[k] !== 9'b1_010_0_0_0_1_0) begin
        errors++; $display("FAIL loaduse_add inst%0d got valid %b ctrl %b expected 1 101000010", k, vld[k], ctl[k]);
      end
    end
  endtask

  task automatic test_imm();
    drive(1'b1, itype(6'h08, 5'd0, 5'd5, 16'h8001), 1'b0, 5'd0, 64'd0, 1'b0, 1'b0);
    tick();
    checks++;
    if (s64 !== 64'hFFFF_FFFF_FFFF_8001 || z64 !== 64'h8001 || ctl[2][4] !== 1'b1) begin
      errors++; $display("FAIL imm64 got s %h z %h alusrc %b expected ffffffffffff8001 8001 1", s64, z64, ctl[2][4]);
    end
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (obs(k) !== m_ex[k]) begin
        errors++; $display("FAIL imm_model inst%0d got %h expected %h", k, obs(k), m_ex[k]);
      end
    end
  endtask

  task automatic test_priority();
    ex_t snap [NI];
    drive(1'b1, itype(6'h23, 5'd1, 5'd2, 16'd4), 1'b0, 5'd0, 64'd0, 1'b0, 1'b0);
    tick();
    drive(1'b1, rtype(5'd2, 5'd2, 5'd3), 1'b0, 5'd0, 64'd0, 1'b1, 1'b1);
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (stall[k] !== 1'b0) begin
        errors++; $display("FAIL prio_stall inst%0d got %b expected 0", k, stall[k]);
      end
    end
    tick();
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (vld[k] !== 1'b0 || ctl[k] !== 9'd0 || ill[k] !== 1'b0) begin
        errors++; $display("FAIL prio_bubble inst%0d got valid %b ctrl %b ill %b expected 0", k, vld[k], ctl[k], ill[k]);
      end
    end
    drive(1'b1, itype(6'h0d, 5'd3, 5'd6, 16'h1234), 1'b0, 5'd0, 64'd0, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < NI; k++) snap[k] = m_ex[k];
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, $urandom, 1'b0, 5'd0, 64'd0, 1'b0, 1'b1);
      for (int k = 0; k < NI; k++) begin
        checks++;
        if (stall[k] !== 1'b1) begin
          errors++; $display("FAIL hold_stall inst%0d cyc%0d got %b expected 1", k, c, stall[k]);
        end
      end
      tick();
      for (int k = 0; k < NI; k++) begin
        checks++;
        if (obs(k) !== snap[k]) begin
          errors++; $display("FAIL hold_keep inst%0d cyc%0d got %h expected %h", k, c, obs(k), snap[k]);
        end
      end
    end
  endtask

  task automatic test_illegal();
    drive(1'b1, itype(6'h3f, 5'd1, 5'd2, 16'h0), 1'b0, 5'd0, 64'd0, 1'b0, 1'b0);
    tick();
    checks++;
    if (ill[0] !== 1'b1 || ctl[0] !== 9'd0) begin
      errors++; $display("FAIL illegal_op got ill %b ctrl %b expected 1 0", ill[0], ctl[0]);
    end
    drive(1'b1, itype(6'h08, 5'd20, 5'd1, 16'h0), 1'b0, 5'd0, 64'd0, 1'b0, 1'b0);
    tick();
    checks++;
    if (ill[3] !== 1'b1 || ctl[3] !== 9'd0 || ill[0] !== 1'b0) begin
      errors++; $display("FAIL illegal_reg got ill16 %b ctrl16 %b ill32 %b expected 1 0 0", ill[3], ctl[3], ill[0]);
    end
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (obs(k) !== m_ex[k]) begin
        errors++; $display("FAIL illegal_model inst%0d got %h expected %h", k, obs(k), m_ex[k]);
      end
    end
  endtask

  task automatic test_random(input int n);
    logic [5:0] ops [7] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h0c, 6'h0d};
    for (int c = 0; c < n; c++) begin
      logic [5:0]  op;
      logic [4:0]  s, t, d;
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 6)];
      s  = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      t  = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      d  = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      drive($urandom_range(0, 99) < 85, {op, s, t, d, 11'($urandom)},
            1'($urandom), 5'($urandom_range(0, 7)), {$urandom, $urandom},
            $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 12);
      for (int k = 0; k < NI; k++) begin
        checks++;
        if (stall[k] !== m_stall(k)) begin
          errors++; $display("FAIL rand_stall inst%0d cyc%0d got %b expected %b", k, c, stall[k], m_stall(k));
        end
      end
      tick();
      for (int k = 0; k < NI; k++) begin
        checks++;
        if (obs(k) !== m_ex[k]) begin
          errors++; $display("FAIL rand_ex inst%0d cyc%0d got %h expected %h", k, c, obs(k), m_ex[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, itype(6'h08, 5'd1, 5'd7, 16'h55), 1'b1, 5'd5, 64'h0000_0000_CAFE_F00D, 1'b0, 1'b0);
    tick();
    drive(1'b1, rtype(5'd5, 5'd5, 5'd6), 1'b0, 5'd0, 64'd0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    m_reset();
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (obs(k) !== ex_t'(0) || stall[k] !== 1'b0) begin
        errors++; $display("FAIL reset_mid inst%0d got %h stall %b expected all zero", k, obs(k), stall[k]);
      end
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, rtype(5'd5, 5'd0, 5'd6), 1'b0, 5'd0, 64'd0, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (obs(k).a !== 64'd0 || obs(k) !== m_ex[k]) begin
        errors++; $display("FAIL reset_rf inst%0d got %h expected %h", k, obs(k), m_ex[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_load_use();
    test_imm();
    test_priority();
    test_illegal();
    test_random(400);
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_stage_p.md
Name: id_stage_p

Overview:
Parametrised instruction-decode stage for the 5-stage MIPS-style pipeline. It decodes the IF/ID instruction, reads a parametrised register file with optional write-back bypass, and sign/zero-extends the immediate. It detects load-use hazards against its own ID/EX register and handles flush and downstream hold. All results are captured in a registered ID/EX pipeline register with a valid bit.

Parameters:
XLEN, 32, datapath width; legal values >=32; immediates extend from 16 bits to XLEN.
NREGS, 32, register count; legal values 8, 16 or 32.
BYPASS, 1, 1 = write-back data is forwarded to same-cycle reads; 0 = plain read of stored value.
AW, $clog2(NREGS), derived register-index width; do not override.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
if_valid  in  1  IF/ID holds a real instruction
if_instr  in  32  IF/ID instruction
wb_we  in  1  write-back enable
wb_rd  in  AW  write-back destination
wb_data  in  XLEN  write-back data
flush  in  1  squash the instruction in ID (branch taken)
ex_hold  in  1  downstream stall; ID/EX must hold
stall_out  out  1  to IF: hold PC and IF/ID this cycle
ex_valid  out  1  ID/EX valid
ex_instr  out  32  ID/EX instruction copy
ex_a  out  XLEN  rs operand
ex_b  out  XLEN  rt operand
ex_imm_s  out  XLEN  sign-extended imm[15:0]
ex_imm_z  out  XLEN  zero-extended imm[15:0]
ex_ctrl  out  9  {RegDst, ALUOp[2:0], ALUSrc, MemRead, MemWrite, RegWrite, MemtoReg}
ex_illegal  out  1  unknown opcode, or register field >= NREGS

Behaviour:
- Reset (async, rst_n=0): all ex_* outputs cleared to 0 immediately; all register-file entries cleared to 0. stall_out is combinational and evaluates to 0 because ex_valid=0.
- Latency: 1 cycle. ID/EX captures decode results on the clk edge.
- Register file:
  - r0 reads as 0 and ignores writes.
  - Write on the clk edge when wb_we=1 and wb_rd!=0.
  - Reads are combinational, using rs/rt = if_instr[25:21]/[20:16] truncated to AW bits.
  - If BYPASS=1, wb_we=1, wb_rd!=0 and wb_rd matches the read index, the read returns wb_data.
- Decode:
  - R-type 000000: RegDst=1, ALUOp=010, RegWrite=1.
  - lw 100011: ALUOp=000, ALUSrc=1, MemRead=1, RegWrite=1, MemtoReg=1.
  - sw 101011: ALUOp=000, ALUSrc=1, MemWrite=1.
  - beq 000100: ALUOp=001.
  - addi 001000: ALUOp=000, ALUSrc=1, RegWrite=1.
  - andi 001100: ALUOp=011, ALUSrc=1, RegWrite=1.
  - ori 001101: ALUOp=100, ALUSrc=1, RegWrite=1.
  - Any other opcode: ctrl=0, illegal=1.
  - Register field with upper bits beyond AW nonzero: ctrl=0, illegal=1.
- Hazard: haz = if_valid & ex_valid & ex_ctrl.MemRead & (ex_instr[20:16]!=0) & (ex_instr[20:16]==rs | ex_instr[20:16]==rt).
- Priority per cycle: rst_n > flush > ex_hold > haz > normal.
  - flush: ID/EX loads a bubble (valid, ctrl, illegal = 0; data don't-care, driven 0). stall_out=0.
  - ex_hold: ID/EX keeps its value. stall_out=1.
  - haz: ID/EX loads a bubble. stall_out=1. IF re-presents the same instruction next cycle.
  - normal: ID/EX loads the decode result. ex_valid=if_valid. ctrl and illegal are forced 0 when if_valid=0.
- stall_out = ~flush & (ex_hold | haz); combinational.
- A write-back and an ID read in the same cycle at the same index follow the BYPASS rule. Register-file writes proceed regardless of flush or hold.

Decomposition:
- Package id_pkg: opcode localparams, ALUOp encodings, ctrl bit-position constants, CTRL_W=9.
- Sub-module regfile_p (XLEN, NREGS, BYPASS): 2 read ports, 1 write port, async-reset clear.
- Decode and hazard logic stay combinational in id_stage_p.

Test Plan:
- Reset mid-run: drive valid traffic, pulse rst_n=0 between edges -> all ex_* = 0 at once; reading r5 after release returns 0.
- Bypass: BYPASS=1, wb_we=1, wb_rd=3, wb_data=0xDEADBEEF, if_instr = add $4,$3,$0 -> next edge ex_a=0xDEADBEEF. With BYPASS=0 the same stimulus gives ex_a = old r3.
- Load-use: lw $2,0($1) then add $3,$2,$2 -> cycle 2 stall_out=1 and ex_valid=0 (bubble); cycle 3 add enters with ex_ctrl=9'b1_010_0_0_0_1_0.
- Immediates: addi with imm=0x8001, XLEN=64 -> ex_imm_s=0xFFFFFFFFFFFF8001, ex_imm_z=0x8001, ALUSrc=1.
- Priority: flush=1 together with ex_hold=1 and a hazard -> stall_out=0 and the bubble is loaded. ex_hold alone for 3 cycles -> ex_* unchanged and stall_out=1.
- Illegal: opcode 111111 -> ex_illegal=1, ex_ctrl=0. With NREGS=16, rs=20 -> ex_illegal=1.
